// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: memory-handshake freeze, load-use bubble,
// branch squash, data-memory timeout detection and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memreadE,
    input  logic [4:0]       dstregE,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             usesrsD,
    input  logic             usesrtD,
    input  logic             branch_takenD,
    input  logic             memreqM,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MWAIT, MERR} state_t;

    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(MEM_TIMEOUT);

    state_t           state, stateNext;
    logic [CNT_W-1:0] waitCnt, stallCnt;
    logic [CNT_W:0]   waitInc;
    logic             loadUse, timeoutHit;

    assign loadUse = memreadE && (dstregE != 5'd0) &&
                     ((usesrsD && (rsD == dstregE)) || (usesrtD && (rtD == dstregE)));

    // Timeout fires on the un-acked cycle that brings the wait count up to the limit.
    assign waitInc    = {1'b0, waitCnt} + (CNT_W+1)'(1);
    assign timeoutHit = (MEM_TIMEOUT != 0) && (waitInc >= TO_LIM);

    assign mem_err   = (state == MERR);
    assign stall_cnt = stallCnt;

    always_comb begin
        stateNext    = state;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        dmem_req     = memreqM;
        case (state)
            RUN: begin
                if (memreqM && !mem_ack) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    dmem_req     = 1'b1;
                    stateNext    = timeoutHit ? MERR : MWAIT;
                end else if (loadUse) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (branch_takenD) begin
                    ifid_flush = 1'b1;
                end
            end
            MWAIT: begin
                dmem_req = 1'b1;
                if (mem_ack) begin
                    stateNext = RUN;
                end else begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    stateNext    = timeoutHit ? MERR : MWAIT;
                end
            end
            MERR: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
                dmem_req     = 1'b0;
            end
            default: stateNext = RUN;
        endcase
        // Reset overrides everything and drops any outstanding request immediately.
        if (rst) begin
            stateNext    = RUN;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_flush   = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            dmem_req     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            waitCnt  <= '0;
            stallCnt <= '0;
        end else begin
            state <= stateNext;
            if (mem_ack)
                waitCnt <= '0;
            else if (dmem_req && (waitCnt != '1))
                waitCnt <= waitCnt + 1'b1;
            if (!pc_en && (stallCnt != '1))
                stallCnt <= stallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and small parameters) driven in
// lockstep and compared each cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, memreadE, usesrsD, usesrtD, branch_takenD, memreqM, mem_ack;
    logic [4:0] dstregE, rsD, rtD;

    // Output vectors: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, dmem_req, mem_err}
    wire [8:0]  oA, oB;
    wire [15:0] stA;
    wire [3:0]  stB;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .memreadE(memreadE), .dstregE(dstregE), .rsD(rsD), .rtD(rtD),
        .usesrsD(usesrsD), .usesrtD(usesrtD), .branch_takenD(branch_takenD),
        .memreqM(memreqM), .mem_ack(mem_ack),
        .pc_en(oA[8]), .ifid_en(oA[7]), .ifid_flush(oA[6]), .idex_en(oA[5]), .idex_flush(oA[4]),
        .exmem_en(oA[3]), .memwb_bubble(oA[2]), .dmem_req(oA[1]), .mem_err(oA[0]), .stall_cnt(stA));

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .memreadE(memreadE), .dstregE(dstregE), .rsD(rsD), .rtD(rtD),
        .usesrsD(usesrsD), .usesrtD(usesrtD), .branch_takenD(branch_takenD),
        .memreqM(memreqM), .mem_ack(mem_ack),
        .pc_en(oB[8]), .ifid_en(oB[7]), .ifid_flush(oB[6]), .idex_en(oB[5]), .idex_flush(oB[4]),
        .exmem_en(oB[3]), .memwb_bubble(oB[2]), .dmem_req(oB[1]), .mem_err(oB[0]), .stall_cnt(stB));

    // mode: 0 running, 1 waiting on memory, 2 errored
    typedef struct {int mode; int waitN; int stalls; bit err;} mst_t;

    mst_t       sA, sB, nA, nB;
    logic [8:0] eA, eB;
    int         total = 0;
    int         bad   = 0;

    function automatic void model(input mst_t s, input int to, input int cmax,
                                  output logic [8:0] o, output mst_t n);
        bit lu, pc, ie, ifl, xe, xfl, me, bub, req;
        lu = memreadE && (dstregE != 0) &&
             ((usesrsD && rsD == dstregE) || (usesrtD && rtD == dstregE));
        n = s;
        {pc, ie, ifl, xe, xfl, me, bub} = 7'b1101010;
        req = memreqM;
        if (rst) begin
            {pc, ie, ifl, xe, xfl, me, bub} = 7'b0010101;
            req = 0;
            n.mode = 0; n.waitN = 0; n.stalls = 0; n.err = 0;
        end else begin
            case (s.mode)
                0: begin
                    if (memreqM && !mem_ack) begin
                        {pc, ie, ifl, xe, xfl, me, bub} = 7'b0000001;
                        req = 1;
                        n.waitN = s.waitN + 1;
                        n.mode = (to != 0 && n.waitN >= to) ? 2 : 1;
                    end else if (lu) begin
                        pc = 0; ie = 0; xfl = 1;
                    end else if (branch_takenD) begin
                        ifl = 1;
                    end
                end
                1: begin
                    req = 1;
                    if (mem_ack) begin
                        n.mode = 0; n.waitN = 0;
                    end else begin
                        {pc, ie, ifl, xe, xfl, me, bub} = 7'b0000001;
                        n.waitN = s.waitN + 1;
                        n.mode = (to != 0 && n.waitN >= to) ? 2 : 1;
                    end
                end
                default: begin
                    {pc, ie, ifl, xe, xfl, me, bub} = 7'b0000001;
                    req = 0;
                end
            endcase
            if (!pc && s.stalls < cmax) n.stalls = s.stalls + 1;
            n.err = (n.mode == 2);
        end
        o = {pc, ie, ifl, xe, xfl, me, bub, req, s.err};
    endfunction

    task automatic setIn(input bit r, input bit mr, input int dst, input int rs, input int rt,
                         input bit urs, input bit urt, input bit br, input bit mq, input bit ack);
        rst = r; memreadE = mr; dstregE = 5'(dst); rsD = 5'(rs); rtD = 5'(rt);
        usesrsD = urs; usesrtD = urt; branch_takenD = br; memreqM = mq; mem_ack = ack;
    endtask

    task automatic eval();
        #1;
        model(sA, 64, 65535, eA, nA);
        model(sB, 4, 15, eB, nB);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sA = nA;
        sB = nB;
    endtask

    task automatic doReset();
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        tick();
    endtask

    task automatic test_reset();
        setIn(1, 1, 8, 8, 8, 1, 1, 1, 1, 0);
        eval();
        if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
            bad++; $display("FAIL reset: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
        end
        total++;
        if (oA !== 9'b001010100) begin
            bad++; $display("FAIL reset_outs: got %b want %b", oA, 9'b001010100);
        end
        total++;
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        if ({stA, oA[0], stB, oB[0]} !== 22'd0) begin
            bad++; $display("FAIL reset_cnt: got stA=%0d errA=%b stB=%0d errB=%b want all 0", stA, oA[0], stB, oB[0]);
        end
        total++;
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) setIn(0, 1, 8, 8, 3, 1, 0, 0, 0, 0);
            else        setIn(0, 1, 8, 4, 5, 1, 1, 0, 0, 0);
            eval();
            if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
                bad++; $display("FAIL load_use c%0d: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", i, oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
            end
            total++;
            if (i == 0 && {oA[8], oA[7], oA[4]} !== 3'b001) begin
                bad++; $display("FAIL load_use_ctl: got pc/ifid_en/idex_flush=%b want 001", {oA[8], oA[7], oA[4]});
            end
            if (i == 0) total++;
            if (i == 1 && stA !== 16'd1) begin
                bad++; $display("FAIL load_use_cnt: got %0d want 1", stA);
            end
            if (i == 1) total++;
            tick();
        end
    endtask

    task automatic test_lu_branch();
        doReset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) setIn(0, 1, 9, 2, 9, 0, 1, 1, 0, 0);
            else        setIn(0, 0, 9, 2, 9, 0, 1, 1, 0, 0);
            eval();
            if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
                bad++; $display("FAIL lu_branch c%0d: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", i, oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
            end
            total++;
            if (oA[6] !== (i == 1)) begin
                bad++; $display("FAIL lu_branch_flush c%0d: got ifid_flush=%b want %b", i, oA[6], (i == 1));
            end
            total++;
            tick();
        end
    endtask

    task automatic test_r0();
        doReset();
        setIn(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        eval();
        if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
            bad++; $display("FAIL r0: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
        end
        total++;
        if (oA[8] !== 1'b1) begin
            bad++; $display("FAIL r0_pc: got pc_en=%b want 1", oA[8]);
        end
        total++;
        tick();
    endtask

    task automatic test_mem_wait();
        doReset();
        for (int i = 0; i < 5; i++) begin
            // Hazard inputs are present throughout and must be ignored while frozen.
            setIn(0, 1, 7, 7, 0, 1, 0, 1, (i < 4), (i == 3));
            eval();
            if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
                bad++; $display("FAIL mem_wait c%0d: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", i, oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
            end
            total++;
            if (i < 3 && {oA[8], oA[2], oA[1]} !== 3'b011) begin
                bad++; $display("FAIL mem_wait_freeze c%0d: got pc/bubble/req=%b want 011", i, {oA[8], oA[2], oA[1]});
            end
            if (i < 3) total++;
            if (i == 3 && oA !== 9'b110101010) begin
                bad++; $display("FAIL mem_wait_ack: got %b want 110101010", oA);
            end
            if (i == 3) total++;
            if (i == 4 && stA !== 16'd3) begin
                bad++; $display("FAIL mem_wait_cnt: got %0d want 3", stA);
            end
            if (i == 4) total++;
            tick();
        end
    endtask

    task automatic test_zero_wait();
        doReset();
        for (int i = 0; i < 2; i++) begin
            setIn(0, 0, 0, 0, 0, 0, 0, 0, (i == 0), (i == 0));
            eval();
            if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
                bad++; $display("FAIL zero_wait c%0d: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", i, oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
            end
            total++;
            if ({oA[8], oA[1]} !== {1'b1, (i == 0)}) begin
                bad++; $display("FAIL zero_wait_req c%0d: got pc/req=%b want %b", i, {oA[8], oA[1]}, {1'b1, (i == 0)});
            end
            total++;
            tick();
        end
    endtask

    task automatic test_timeout();
        doReset();
        for (int i = 0; i < 7; i++) begin
            setIn(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            eval();
            if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
                bad++; $display("FAIL timeout c%0d: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", i, oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
            end
            total++;
            if ({oB[0], oB[1], oB[8]} !== {(i >= 4), (i < 4), 1'b0}) begin
                bad++; $display("FAIL timeout_err c%0d: got err/req/pc=%b want %b", i, {oB[0], oB[1], oB[8]}, {(i >= 4), (i < 4), 1'b0});
            end
            total++;
            tick();
        end
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        eval();
        if (oB[1] !== 1'b0) begin
            bad++; $display("FAIL timeout_rstreq: got dmem_req=%b want 0", oB[1]);
        end
        total++;
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        if ({oB[0], stB, oA[0], stA} !== 22'd0) begin
            bad++; $display("FAIL timeout_clear: got errB=%b stB=%0d errA=%b stA=%0d want all 0", oB[0], stB, oA[0], stA);
        end
        total++;
        tick();
    endtask

    task automatic test_saturate();
        doReset();
        for (int i = 0; i < 21; i++) begin
            if (i < 20) setIn(0, 1, 12, 12, 0, 1, 0, 0, 0, 0);
            else        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            eval();
            if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
                bad++; $display("FAIL saturate c%0d: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", i, oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
            end
            total++;
            tick();
        end
        if ({stB, stA} !== {4'd15, 16'd20}) begin
            bad++; $display("FAIL saturate_cnt: got stB=%0d stA=%0d want 15 20", stB, stA);
        end
        total++;
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 3000; i++) begin
            setIn(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0));
            eval();
            if ({oA, oB, stA, stB} !== {eA, eB, 16'(sA.stalls), 4'(sB.stalls)}) begin
                bad++; $display("FAIL random c%0d: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d", i, oA, stA, oB, stB, eA, sA.stalls, eB, sB.stalls);
            end
            total++;
            tick();
        end
    endtask

    initial begin
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        sA.mode = 0; sA.waitN = 0; sA.stalls = 0; sA.err = 0;
        sB = sA;
        test_reset();
        test_load_use();
        test_lu_branch();
        test_r0();
        test_mem_wait();
        test_zero_wait();
        test_timeout();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
